// File: rtl/page_switcher.sv
// page_switcher: debounced next/prev/jump page selection, committed at frame_start,
// with registered routing of buttons to the active page and pixels from it.
module page_switcher #(
    parameter int NUM_PAGES       = 4,
    parameter int BTN_WIDTH       = 16,
    parameter int PIX_WIDTH       = 12,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_PAGE      = 0
) (
    input  logic                           vga_clk,
    input  logic                           vga_rst,
    input  logic                           btn_next,
    input  logic                           btn_prev,
    input  logic                           jump_valid,
    input  logic [2:0]                     jump_page,
    input  logic                           frame_start,
    input  logic [BTN_WIDTH-1:0]           btns_in,
    output logic [NUM_PAGES*BTN_WIDTH-1:0] btns_out,
    input  logic [NUM_PAGES*PIX_WIDTH-1:0] pix_in,
    output logic [PIX_WIDTH-1:0]           pix_out,
    output logic [2:0]                     page_cur,
    output logic                           switch_pending
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    raw, lvl, lvl_d, rise;
    logic [CW-1:0] cnt [2];
    logic [2:0]    tgt, base, inc, dec, new_tgt;
    logic          pend, jump_ok, req;
    assign raw            = {btn_prev, btn_next};
    assign rise           = lvl & ~lvl_d;
    assign switch_pending = pend;
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            lvl    <= '0;
            lvl_d  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            lvl_d <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl[i] <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
    // Requests chain off the pending target so several presses within a frame accumulate.
    always_comb begin
        base    = pend ? tgt : page_cur;
        inc     = (base == 3'(NUM_PAGES - 1)) ? 3'd0 : base + 3'd1;
        dec     = (base == 3'd0) ? 3'(NUM_PAGES - 1) : base - 3'd1;
        jump_ok = jump_valid && ({1'b0, jump_page} < 4'(NUM_PAGES));
        req     = jump_ok | rise[0] | rise[1];
        new_tgt = jump_ok ? jump_page : rise[0] ? inc : dec;
    end
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            page_cur <= 3'(RESET_PAGE);
            tgt      <= 3'(RESET_PAGE);
            pend     <= 1'b0;
        end else begin
            if (frame_start && pend)
                page_cur <= tgt;
            if (req) begin
                tgt  <= new_tgt;
                pend <= 1'b1;
            end else if (frame_start) begin
                pend <= 1'b0;
            end
        end
    end
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            btns_out <= '0;
            pix_out  <= '0;
        end else begin
            pix_out <= '0;
            for (int k = 0; k < NUM_PAGES; k++) begin
                btns_out[k*BTN_WIDTH +: BTN_WIDTH] <= (page_cur == 3'(k)) ? btns_in : '0;
                if (page_cur == 3'(k))
                    pix_out <= pix_in[k*PIX_WIDTH +: PIX_WIDTH];
            end
        end
    end
endmodule

// File: doc/page_switcher.md
PAGE_SWITCHER -- requirements
Module: page_switcher

Interface
REQ-001 SHALL have parameter NUM_PAGES, default 4, meaning the number of selectable pages (legal range 2..8).
REQ-002 SHALL have parameter BTN_WIDTH, default 16, meaning the width of the button bus routed to pages.
REQ-003 SHALL have parameter PIX_WIDTH, default 12, meaning the pixel width in RGB444.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of stable cycles required before a debounced level changes (20 ms at 25 MHz).
REQ-005 SHALL have parameter RESET_PAGE, default 0, meaning the page selected after reset (must be below NUM_PAGES).
REQ-006 SHALL have port vga_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port vga_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port btn_next, input, 1 bit: raw, undebounced "next page" key.
REQ-009 SHALL have port btn_prev, input, 1 bit: raw, undebounced "previous page" key.
REQ-010 SHALL have port jump_valid, input, 1 bit: one-cycle request to jump directly to page jump_page.
REQ-011 SHALL have port jump_page, input, 3 bits: target page index for jump_valid.
REQ-012 SHALL have port frame_start, input, 1 bit: one-cycle pulse from the VGA timing block at the start of vertical blank.
REQ-013 SHALL have port btns_in, input, BTN_WIDTH bits: the scanned key matrix state.
REQ-014 SHALL have port btns_out, output, NUM_PAGES*BTN_WIDTH bits: per-page button buses; slice k occupies bits [k*BTN_WIDTH +: BTN_WIDTH].
REQ-015 SHALL have port pix_in, input, NUM_PAGES*PIX_WIDTH bits: per-page pixel data; slice k occupies bits [k*PIX_WIDTH +: PIX_WIDTH].
REQ-016 SHALL have port pix_out, output, PIX_WIDTH bits: pixel data of the selected page, sent to the VGA block.
REQ-017 SHALL have port page_cur, output, 3 bits: index of the page currently displayed.
REQ-018 SHALL have port switch_pending, output, 1 bit: high while an accepted request waits for frame_start.

Function
REQ-019 SHALL debounce btn_next and btn_prev independently: each has a saturating counter, cleared whenever raw equals the debounced level; when the counter reaches DEBOUNCE_CYCLES-1 with raw still different, the debounced level takes the raw value and the counter clears.
REQ-020 SHALL generate a one-cycle next or prev event on the rising edge of the corresponding debounced level only; falling edges produce nothing.
REQ-021 SHALL compute the request base as the pending target if switch_pending is high, else page_cur.
REQ-022 SHALL give simultaneous events the priority jump > next > prev; lower-priority events in that cycle are dropped.
REQ-023 SHALL set the target to base+1 for next, wrapping NUM_PAGES-1 to 0; to base-1 for prev, wrapping 0 to NUM_PAGES-1; to jump_page for a jump.
REQ-024 SHALL ignore jump_valid when jump_page >= NUM_PAGES, with no state change and no drop of lower-priority events that cycle.
REQ-025 SHALL, on an accepted request, load the pending target and set switch_pending the next cycle; later requests before frame_start overwrite the target per REQ-021.
REQ-026 SHALL, on frame_start with switch_pending high, load page_cur from the pending target.
REQ-027 SHALL, when a request and frame_start occur in the same cycle, have page_cur take the old pending target (if any) while the new request becomes pending (base = old pending target); with nothing previously pending, page_cur is unchanged and the request pends.
REQ-028 SHALL keep page_cur fixed when switch_pending is high and the target equals page_cur; switch_pending clears at frame_start.
REQ-029 SHALL register btns_out with 1-cycle latency: slice page_cur = btns_in, all other slices = 0.
REQ-030 SHALL register pix_out with 1-cycle latency: pix_out = slice page_cur of pix_in.
REQ-031 SHALL make a page change visible on btns_out/pix_out one cycle after page_cur updates.

Reset
REQ-032 SHALL, on vga_rst high at a clock edge, set page_cur = RESET_PAGE, switch_pending = 0, pending target = RESET_PAGE, pix_out = 0, btns_out = 0, and debounced levels and counters = 0.
REQ-033 SHALL make reset override all events in the same cycle; a mid-debounce or pending switch is discarded.

Verification
REQ-034 SHALL verify reset: NUM_PAGES=4, hold vga_rst 2 cycles -> page_cur=0, switch_pending=0, pix_out=0, btns_out=0.
REQ-035 SHALL verify debounce: DEBOUNCE_CYCLES=8, btn_next glitch high 5 cycles -> no pending; held high 8 cycles -> switch_pending=1; frame_start -> page_cur=1.
REQ-036 SHALL verify wrap-around: from page 3, next + frame_start -> page 0; prev + frame_start -> page 3.
REQ-037 SHALL verify accumulation: page 0, two next events before frame_start -> page_cur=2 after a single frame_start.
REQ-038 SHALL verify priority: jump_valid with jump_page=2 plus a next event in the same cycle -> page 2; jump_page=5 plus next -> page 1.
REQ-039 SHALL verify routing: page 2 selected, btns_in=16'h00A5, pix_in slice2=12'hF0F -> next cycle btns_out slice2=16'h00A5, other slices 0, pix_out=12'hF0F.
